// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the wall-clock timekeeping controller.
// State codes, counter widths and wrap limits used by clock_time_ctrl.
// The optional alarm states are always defined here; only the controller
// decides (via CLOCK_ALARM_EN) whether they are ever reached.

package clock_ctrl_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int MODE_W = 3;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_MAX);
    localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MIN_MAX);

    // Mode codes as seen on the mode output.
    typedef enum logic [MODE_W-1:0] {
        ST_RUN       = 3'd0,
        ST_SET_HOUR  = 3'd1,
        ST_SET_MIN   = 3'd2,
        ST_SET_ALM_H = 3'd3,
        ST_SET_ALM_M = 3'd4
    } state_e;

    // Increment a 6-bit minutes/seconds style field, wrapping to 0 after last.
    function automatic logic [5:0] wrap_inc6(input logic [5:0] value,
                                             input logic [5:0] last);
        logic [5:0] result;
        if (value == last) begin
            result = '0;
        end else begin
            result = value + 6'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/clock_time_ctrl_tick_sync_edge.sv
// Brings the 1 Hz square wave into the system clock domain and turns each
// rising edge into a single-cycle registered tick.
// Latency: tick is high SYNC_STAGES clock edges after the edge that first
// samples the input high, so the consumer updates one edge later still.

module tick_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic async_in,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;
    logic                   tick_q;
    logic                   tick_d;

    // Shift the raw input through the synchronizer chain and compare the
    // settled value against its previous sample to find rising edges.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
        tick_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    // Synchronizer, edge history and tick register; all cleared on reset so a
    // wave that is already high at release still yields one first tick.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping controller: runs the hh:mm:ss counters from the synchronized
// 1 Hz wave and sequences the button-driven set-mode FSM.
// Optional feature macro: CLOCK_ALARM_EN adds alarm hour/minute set states,
// the alarm_arm input and the registered alarm_on output.
// Every output comes straight from a flop.

module clock_time_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int HOUR_MODULO = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              clk_1hz_in,
    input  logic              btn_mode,
    input  logic              btn_inc,
`ifdef CLOCK_ALARM_EN
    input  logic              alarm_arm,
    output logic              alarm_on,
`endif
    output logic [HOUR_W-1:0] hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [SEC_W-1:0]  seconds,
    output logic [MODE_W-1:0] mode,
    output logic              sec_pulse
);

    localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MODULO - 1);

    logic              tick;

    state_e            state_q;
    state_e            state_d;
    logic [HOUR_W-1:0] hours_q;
    logic [HOUR_W-1:0] hours_d;
    logic [MIN_W-1:0]  minutes_q;
    logic [MIN_W-1:0]  minutes_d;
    logic [SEC_W-1:0]  seconds_q;
    logic [SEC_W-1:0]  seconds_d;
    logic              sec_pulse_q;
    logic              sec_pulse_d;

`ifdef CLOCK_ALARM_EN
    logic [HOUR_W-1:0] alm_h_q;
    logic [HOUR_W-1:0] alm_h_d;
    logic [MIN_W-1:0]  alm_m_q;
    logic [MIN_W-1:0]  alm_m_d;
    logic              alarm_on_q;
    logic              alarm_on_d;
`endif

    // Hour counter wrap depends on the 12/24 hour build parameter.
    function automatic logic [HOUR_W-1:0] next_hour(input logic [HOUR_W-1:0] h);
        logic [HOUR_W-1:0] result;
        if (h == HOUR_LAST) begin
            result = '0;
        end else begin
            result = h + HOUR_W'(1);
        end
        return result;
    endfunction

    tick_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tick_sync_edge (
        .clk_in   (clk_in),
        .rst      (rst),
        .async_in (clk_1hz_in),
        .tick     (tick)
    );

    // Next-state logic: in RUN a tick advances the time with carries; in the
    // set states ticks are dropped and btn_inc bumps one field without carry.
    // btn_mode always takes priority over btn_inc in the same cycle.
    always_comb begin
        state_d     = state_q;
        hours_d     = hours_q;
        minutes_d   = minutes_q;
        seconds_d   = seconds_q;
        sec_pulse_d = tick;
`ifdef CLOCK_ALARM_EN
        alm_h_d     = alm_h_q;
        alm_m_d     = alm_m_q;
        alarm_on_d  = (state_q == ST_RUN) && alarm_arm &&
                      (hours_q == alm_h_q) && (minutes_q == alm_m_q);
`endif

        case (state_q)
            ST_RUN: begin
                if (tick) begin
                    if (seconds_q == SEC_LAST) begin
                        seconds_d = '0;
                        if (minutes_q == MIN_LAST) begin
                            minutes_d = '0;
                            hours_d   = next_hour(hours_q);
                        end else begin
                            minutes_d = minutes_q + MIN_W'(1);
                        end
                    end else begin
                        seconds_d = seconds_q + SEC_W'(1);
                    end
                end
                if (btn_mode) begin
                    state_d = ST_SET_HOUR;
                end
            end

            ST_SET_HOUR: begin
                if (btn_mode) begin
                    state_d = ST_SET_MIN;
                end else if (btn_inc) begin
                    hours_d = next_hour(hours_q);
                end
            end

            ST_SET_MIN: begin
                if (btn_mode) begin
`ifdef CLOCK_ALARM_EN
                    state_d   = ST_SET_ALM_H;
`else
                    state_d   = ST_RUN;
                    seconds_d = '0;
`endif
                end else if (btn_inc) begin
                    minutes_d = wrap_inc6(minutes_q, MIN_LAST);
                end
            end

`ifdef CLOCK_ALARM_EN
            ST_SET_ALM_H: begin
                if (btn_mode) begin
                    state_d = ST_SET_ALM_M;
                end else if (btn_inc) begin
                    alm_h_d = next_hour(alm_h_q);
                end
            end

            ST_SET_ALM_M: begin
                if (btn_mode) begin
                    state_d   = ST_RUN;
                    seconds_d = '0;
                end else if (btn_inc) begin
                    alm_m_d = wrap_inc6(alm_m_q, MIN_LAST);
                end
            end
`endif

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and time registers; reset returns everything to 00:00:00 in RUN.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            hours_q     <= '0;
            minutes_q   <= '0;
            seconds_q   <= '0;
            sec_pulse_q <= 1'b0;
`ifdef CLOCK_ALARM_EN
            alm_h_q     <= '0;
            alm_m_q     <= '0;
            alarm_on_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hours_q     <= hours_d;
            minutes_q   <= minutes_d;
            seconds_q   <= seconds_d;
            sec_pulse_q <= sec_pulse_d;
`ifdef CLOCK_ALARM_EN
            alm_h_q     <= alm_h_d;
            alm_m_q     <= alm_m_d;
            alarm_on_q  <= alarm_on_d;
`endif
        end
    end

    assign hours     = hours_q;
    assign minutes   = minutes_q;
    assign seconds   = seconds_q;
    assign mode      = state_q;
    assign sec_pulse = sec_pulse_q;
`ifdef CLOCK_ALARM_EN
    assign alarm_on  = alarm_on_q;
`endif

endmodule
